can_xl_bit_monitor: RTL and testbench
=====================================

# can_xl_bit_monitor

Parametrised bit monitor for the CAN XL transmitter path. It compares every transmitted bit against the bus value sampled back. In arbitration phase it checks at the nominal sample point. In XL data phase it checks at the secondary sample point (SSP) through a transmitter-delay-compensation (TDC) FIFO. It sits between the bit-timing unit (strobes, sampled bit) and the frame FSM / error-confinement logic (error pulses, arbitration loss, error count).

## Interface
- TDC_DEPTH, 8: maximum data-phase bits in flight between transmit and SSP; power of two, ≥2
- ERR_CNT_W, 8: width of saturating bit-error counter
- clk  in  1  system clock
- g_rst_n  in  1  reset, asynchronous, active-low
- mon_en  in  1  node is transmitting; 0 disables checking and flushes FIFO
- xl_data_ph  in  1  1 = XL data phase (SSP path), 0 = arbitration-phase path
- bit_tick  in  1  one-cycle strobe at each transmitted bit start
- smp_tick  in  1  one-cycle strobe at nominal sample point
- ssp_tick  in  1  one-cycle strobe at secondary sample point
- can_bus_out  in  1  bit currently driven; 1 = recessive, 0 = dominant
- sampled_bit  in  1  bus value from bit-timing unit, valid on smp_tick/ssp_tick
- rx_mask  in  1  from frame FSM; sent-recessive/read-dominant is legal for this bit (arbitration field, ACK slot, passive error flag, overload/IFS)
- err_clr  in  1  clears err_cnt and tdc_err
- bt_err  out  1  one-cycle bit-error pulse
- bt_err_dom  out  1  qualifies bt_err: 1 = sent recessive, read dominant; 0 = sent dominant, read recessive
- arb_lost  out  1  one-cycle pulse: masked recessive/dominant mismatch in arbitration phase
- err_cnt  out  ERR_CNT_W  saturating count of bt_err pulses
- tdc_err  out  1  sticky: FIFO overflow or SSP with FIFO empty
- fifo_lvl  out  $clog2(TDC_DEPTH)+1  current FIFO occupancy

## Operation
- Arbitration path (xl_data_ph=0), on smp_tick with mon_en=1, compare live can_bus_out vs sampled_bit:
  - equal: no event
  - sent 0, read 1: bt_err, bt_err_dom=0
  - sent 1, read 0, rx_mask=1: arb_lost, no bt_err
  - sent 1, read 0, rx_mask=0: bt_err, bt_err_dom=1
- Data path (xl_data_ph=1):
  - on bit_tick, push entry {rx_mask, can_bus_out}
  - on ssp_tick, pop the oldest entry and compare its bit vs sampled_bit
  - any mismatch is bt_err; the stored mask is ignored except that a masked recessive/dominant mismatch gives no event. arb_lost is never raised in the data phase.
- bit_tick and ssp_tick in the same cycle: push and pop both happen, level unchanged; the popped entry is the pre-existing oldest.
- Push when full (no simultaneous pop): entry dropped, tdc_err set.
- ssp_tick when empty: no compare, tdc_err set.
- FIFO flushes (level 0, pointers 0) on any xl_data_ph edge and whenever mon_en=0. A flush in the same cycle as a push discards the push.
- mon_en=0: no bt_err and no arb_lost; strobes are ignored.
- err_cnt increments on each bt_err and holds at all-ones. err_clr has priority over a simultaneous increment; tdc_err set and err_clr together leave tdc_err = 1.

## Timing
- Reset: bt_err, bt_err_dom, arb_lost, err_cnt, tdc_err, fifo_lvl all 0; FIFO empty.
- bt_err, bt_err_dom and arb_lost are registered and assert exactly 1 cycle after the qualifying smp_tick/ssp_tick, for one cycle. bt_err_dom is 0 whenever bt_err is 0.
- err_cnt updates on the same edge bt_err asserts (visible with the pulse).
- fifo_lvl reflects a push/pop 1 cycle after the strobe.
- Reset asserted mid-frame clears everything immediately (asynchronous). Deassertion is synchronous to clk.

## Configuration
- CANXL_BM_ERR_CNT_EN defined: err_cnt counter implemented as above.
- Not defined: no counter flops; err_cnt tied to 0; err_clr affects only tdc_err.

## Structure
- Shared package canxl_pkg:
  - localparam recessive/dominant bit constants
  - TDC entry typedef {mask, bit}
  - error-kind enum (none, bit0, bit1, arb_lost)
- One sub-module canxl_bm_tdc_fifo: TDC_DEPTH-entry circular buffer with push/pop/flush, level, overflow and underflow flags. The comparator and counter stay in the top.

## Test plan
- Arbitration, rx_mask=1, can_bus_out=1, sampled_bit=0 at smp_tick -> arb_lost=1 one cycle later, bt_err=0.
- Arbitration, rx_mask=0, can_bus_out=0, sampled_bit=1 -> bt_err=1, bt_err_dom=0, err_cnt 0→1.
- Data phase:
  - push bits 1,0,1 on three bit_ticks; fifo_lvl=3
  - first ssp_tick, sampled_bit=1: no error
  - second ssp_tick, sampled_bit=1: bt_err=1, bt_err_dom=0
- Data phase, TDC_DEPTH=8: 9 bit_ticks without ssp_tick -> fifo_lvl=8, tdc_err=1. Then ssp_tick on empty after flush via xl_data_ph toggle -> tdc_err stays 1, no bt_err.
- ERR_CNT_W=2: 5 bt_err events -> err_cnt saturates at 3. err_clr with a coincident bt_err -> err_cnt=0.
- g_rst_n low mid-data-phase with fifo_lvl=4 -> all outputs 0 immediately; after release, first ssp_tick sets tdc_err.

Source files
------------

// File: rtl/canxl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : canxl_pkg
// Description : Shared definitions for the CAN XL bit monitor: bus level
//               constants, the TDC FIFO entry layout, the bit-check result
//               kinds and the mismatch classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package canxl_pkg;

    localparam logic c_BIT_REC = 1'b1;   // recessive bus level
    localparam logic c_BIT_DOM = 1'b0;   // dominant bus level

    // One transmitted bit waiting in the TDC FIFO for its SSP.
    typedef struct packed {
        logic mask;      // recessive-sent/dominant-read is legal for this bit
        logic bit_val;   // level that was driven on the bus
    } tdc_entry_t;

    // Outcome of one bit comparison.
    //   ERR_BIT0 : sent dominant, read recessive
    //   ERR_BIT1 : sent recessive, read dominant (not masked)
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BIT0     = 2'd1,
        ERR_BIT1     = 2'd2,
        ERR_ARB_LOST = 2'd3
    } err_kind_e;

    // Classify a sent/read pair. A masked recessive/dominant mismatch is
    // arbitration loss in the arbitration phase and silently accepted in
    // the data phase.
    function automatic err_kind_e classify(
        input logic sent,
        input logic rd,
        input logic mask,
        input logic arb_ph
    );
        err_kind_e kind;
        kind = ERR_NONE;
        if (sent == c_BIT_DOM && rd == c_BIT_REC) begin
            kind = ERR_BIT0;
        end else if (sent == c_BIT_REC && rd == c_BIT_DOM) begin
            if (!mask) begin
                kind = ERR_BIT1;
            end else if (arb_ph) begin
                kind = ERR_ARB_LOST;
            end
        end
        return kind;
    endfunction

endpackage
`default_nettype wire

// File: rtl/canxl_bm_tdc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : canxl_bm_tdc_fifo
// Description : Transmitter-delay-compensation FIFO. Holds the bits sent in
//               the XL data phase until their secondary sample point. DEPTH
//               entry circular buffer with push, pop, flush, occupancy and
//               overflow/underflow indications. The read port shows the
//               oldest entry combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module canxl_bm_tdc_fifo
    import canxl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  tdc_entry_t               i_wr_data,
    input  logic                     i_pop,
    output tdc_entry_t               o_rd_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_pop_ok,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int                AW         = $clog2(DEPTH);
    localparam logic [AW:0]       c_FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0]       c_LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]     c_PTR_ONE  = AW'(1);

    tdc_entry_t      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;

    logic            w_empty;
    logic            w_full;
    logic            w_pop_ok;
    logic            w_push_ok;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when paired with a successful pop. A flush discards
    // any push of the same cycle.
    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == c_FULL);
    assign w_pop_ok    = i_pop && !w_empty;
    assign w_push_ok   = i_push && !i_flush && (!w_full || w_pop_ok);

    assign o_pop_ok    = w_pop_ok;
    assign o_overflow  = i_push && !i_flush && w_full && !w_pop_ok;
    assign o_underflow = i_pop && w_empty;
    assign o_rd_data   = r_mem[r_rd_ptr];
    assign o_level     = r_level;

    // Pointer and occupancy tracking; flush returns to the empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below the level count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/can_xl_bit_monitor.sv
`default_nettype none
// ============================================================================
// Module      : can_xl_bit_monitor
// Description : CAN XL transmitter bit monitor. Compares each transmitted bit
//               with the sampled bus value: live at the nominal sample point
//               in the arbitration phase, and through the TDC FIFO at the
//               secondary sample point in the XL data phase. Produces
//               registered bit-error / arbitration-loss pulses, a sticky TDC
//               error flag and a saturating bit-error counter.
//               Build option: CANXL_BM_ERR_CNT_EN - when defined the error
//               counter is implemented; otherwise err_cnt is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module can_xl_bit_monitor
    import canxl_pkg::*;
#(
    parameter int TDC_DEPTH = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         g_rst_n,
    input  logic                         mon_en,
    input  logic                         xl_data_ph,
    input  logic                         bit_tick,
    input  logic                         smp_tick,
    input  logic                         ssp_tick,
    input  logic                         can_bus_out,
    input  logic                         sampled_bit,
    input  logic                         rx_mask,
    input  logic                         err_clr,
    output logic                         bt_err,
    output logic                         bt_err_dom,
    output logic                         arb_lost,
    output logic [ERR_CNT_W-1:0]         err_cnt,
    output logic                         tdc_err,
    output logic [$clog2(TDC_DEPTH):0]   fifo_lvl
);

    logic        r_xl_ph_q;
    logic        r_bt_err;
    logic        r_bt_err_dom;
    logic        r_arb_lost;
    logic        r_tdc_err;

    logic        w_flush;
    logic        w_push;
    logic        w_pop;
    tdc_entry_t  w_push_entry;
    tdc_entry_t  w_rd_entry;
    logic        w_pop_ok;
    logic        w_overflow;
    logic        w_underflow;
    err_kind_e   w_kind;
    logic        w_bt_err_nxt;

    // The FIFO only ever holds data-phase bits; a phase change or leaving
    // transmit mode invalidates everything still in flight.
    assign w_flush      = !mon_en || (xl_data_ph != r_xl_ph_q);
    assign w_push       = mon_en && xl_data_ph && bit_tick;
    assign w_pop        = mon_en && xl_data_ph && ssp_tick;
    assign w_push_entry = '{mask: rx_mask, bit_val: can_bus_out};

    canxl_bm_tdc_fifo #(
        .DEPTH (TDC_DEPTH)
    ) u_tdc_fifo (
        .clk         (clk),
        .rst_n       (g_rst_n),
        .i_flush     (w_flush),
        .i_push      (w_push),
        .i_wr_data   (w_push_entry),
        .i_pop       (w_pop),
        .o_rd_data   (w_rd_entry),
        .o_level     (fifo_lvl),
        .o_pop_ok    (w_pop_ok),
        .o_overflow  (w_overflow),
        .o_underflow (w_underflow)
    );

    // Select the comparison for this cycle: live bit at the nominal sample
    // point, or the delayed FIFO bit at the secondary sample point.
    always_comb begin
        w_kind = ERR_NONE;
        if (mon_en && !xl_data_ph && smp_tick) begin
            w_kind = classify(can_bus_out, sampled_bit, rx_mask, 1'b1);
        end else if (w_pop_ok) begin
            w_kind = classify(w_rd_entry.bit_val, sampled_bit, w_rd_entry.mask, 1'b0);
        end
    end

    assign w_bt_err_nxt = (w_kind == ERR_BIT0) || (w_kind == ERR_BIT1);

    // Registered one-cycle event pulses, phase history and sticky TDC flag.
    always_ff @(posedge clk or negedge g_rst_n) begin
        if (!g_rst_n) begin
            r_xl_ph_q    <= 1'b0;
            r_bt_err     <= 1'b0;
            r_bt_err_dom <= 1'b0;
            r_arb_lost   <= 1'b0;
            r_tdc_err    <= 1'b0;
        end else begin
            r_xl_ph_q    <= xl_data_ph;
            r_bt_err     <= w_bt_err_nxt;
            r_bt_err_dom <= (w_kind == ERR_BIT1);
            r_arb_lost   <= (w_kind == ERR_ARB_LOST);
            if (w_overflow || w_underflow) begin
                r_tdc_err <= 1'b1;
            end else if (err_clr) begin
                r_tdc_err <= 1'b0;
            end
        end
    end

    assign bt_err     = r_bt_err;
    assign bt_err_dom = r_bt_err_dom;
    assign arb_lost   = r_arb_lost;
    assign tdc_err    = r_tdc_err;

`ifdef CANXL_BM_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Saturating bit-error counter; a clear wins over a coincident error.
    always_ff @(posedge clk or negedge g_rst_n) begin
        if (!g_rst_n) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (w_bt_err_nxt && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_can_xl_bit_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_can_xl_bit_monitor
// Description : Self-checking bench for can_xl_bit_monitor (TDC_DEPTH=8,
//               ERR_CNT_W=2). A queue-based reference model predicts every
//               output one cycle after the applied inputs. Counter
//               expectations follow CANXL_BM_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_can_xl_bit_monitor;

    localparam int DEPTH = 8;
    localparam int CW    = 2;

    logic clk = 1'b0;
    logic g_rst_n = 1'b0;
    logic mon_en = 1'b0, xl_data_ph = 1'b0;
    logic bit_tick = 1'b0, smp_tick = 1'b0, ssp_tick = 1'b0;
    logic can_bus_out = 1'b1, sampled_bit = 1'b1, rx_mask = 1'b0, err_clr = 1'b0;
    logic bt_err, bt_err_dom, arb_lost, tdc_err;
    logic [CW-1:0] err_cnt;
    logic [3:0]    fifo_lvl;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0] mq[$];          // {mask, bit}, oldest at index 0
    logic       m_prev_xl = 1'b0;
    logic       m_bt = 1'b0, m_dom = 1'b0, m_arb = 1'b0, m_tdc = 1'b0;
    int         m_cnt = 0;

    can_xl_bit_monitor #(.TDC_DEPTH(DEPTH), .ERR_CNT_W(CW)) dut (
        .clk(clk), .g_rst_n(g_rst_n), .mon_en(mon_en), .xl_data_ph(xl_data_ph),
        .bit_tick(bit_tick), .smp_tick(smp_tick), .ssp_tick(ssp_tick),
        .can_bus_out(can_bus_out), .sampled_bit(sampled_bit), .rx_mask(rx_mask),
        .err_clr(err_clr), .bt_err(bt_err), .bt_err_dom(bt_err_dom),
        .arb_lost(arb_lost), .err_cnt(err_cnt), .tdc_err(tdc_err), .fifo_lvl(fifo_lvl)
    );

    always #5 clk = ~clk;

    function automatic void judge(input logic sent, input logic rd, input logic msk, input logic arb);
        if (sent == rd) return;
        if (sent == 1'b0) begin
            m_bt = 1'b1; m_dom = 1'b0;
        end else if (msk) begin
            if (arb) m_arb = 1'b1;
        end else begin
            m_bt = 1'b1; m_dom = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_prev_xl = 1'b0;
        m_bt = 1'b0; m_dom = 1'b0; m_arb = 1'b0; m_tdc = 1'b0; m_cnt = 0;
    endfunction

    // Advance the model by one clock using the current inputs, then clock
    // the DUT and return 1 ns after the edge with strobes cleared.
    task automatic step();
        logic flush, tdc_ev, popped;
        m_bt = 1'b0; m_dom = 1'b0; m_arb = 1'b0;
        tdc_ev = 1'b0; popped = 1'b0;
        flush = !mon_en || (xl_data_ph != m_prev_xl);
        if (mon_en && !xl_data_ph && smp_tick)
            judge(can_bus_out, sampled_bit, rx_mask, 1'b1);
        if (mon_en && xl_data_ph && ssp_tick) begin
            if (mq.size() == 0) tdc_ev = 1'b1;
            else begin
                judge(mq[0][0], sampled_bit, mq[0][1], 1'b0);
                popped = 1'b1;
            end
        end
        if (flush) mq.delete();
        else begin
            if (popped) void'(mq.pop_front());
            if (mon_en && xl_data_ph && bit_tick) begin
                if (mq.size() < DEPTH) mq.push_back({rx_mask, can_bus_out});
                else tdc_ev = 1'b1;
            end
        end
`ifdef CANXL_BM_ERR_CNT_EN
        if (err_clr) m_cnt = 0;
        else if (m_bt && m_cnt < (1 << CW) - 1) m_cnt++;
`endif
        if (tdc_ev) m_tdc = 1'b1;
        else if (err_clr) m_tdc = 1'b0;
        m_prev_xl = xl_data_ph;
        @(posedge clk);
        #1;
        bit_tick = 1'b0; smp_tick = 1'b0; ssp_tick = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        g_rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bt_err !== 1'b0)     begin errors++; $display("FAIL reset_bt_err got %b want 0", bt_err); end
        checks++; if (bt_err_dom !== 1'b0) begin errors++; $display("FAIL reset_bt_err_dom got %b want 0", bt_err_dom); end
        checks++; if (arb_lost !== 1'b0)   begin errors++; $display("FAIL reset_arb_lost got %b want 0", arb_lost); end
        checks++; if (err_cnt !== '0)      begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        checks++; if (tdc_err !== 1'b0)    begin errors++; $display("FAIL reset_tdc_err got %b want 0", tdc_err); end
        checks++; if (fifo_lvl !== 4'd0)   begin errors++; $display("FAIL reset_fifo_lvl got %0d want 0", fifo_lvl); end
        @(negedge clk);
        g_rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_arbitration();
        mon_en = 1'b1; xl_data_ph = 1'b0;
        step();
        // masked recessive/dominant: arbitration lost, no bit error
        rx_mask = 1'b1; can_bus_out = 1'b1; sampled_bit = 1'b0; smp_tick = 1'b1;
        step();
        checks++; if (arb_lost !== 1'b1) begin errors++; $display("FAIL arb_lost_pulse got %b want 1", arb_lost); end
        checks++; if (bt_err !== 1'b0)   begin errors++; $display("FAIL arb_lost_no_bterr got %b want 0", bt_err); end
        step();
        checks++; if (arb_lost !== 1'b0) begin errors++; $display("FAIL arb_lost_one_cycle got %b want 0", arb_lost); end
        // sent dominant, read recessive
        rx_mask = 1'b0; can_bus_out = 1'b0; sampled_bit = 1'b1; smp_tick = 1'b1;
        step();
        checks++; if (bt_err !== 1'b1)     begin errors++; $display("FAIL arb_bit0_bt_err got %b want 1", bt_err); end
        checks++; if (bt_err_dom !== 1'b0) begin errors++; $display("FAIL arb_bit0_dom got %b want 0", bt_err_dom); end
        checks++; if (err_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL arb_bit0_err_cnt got %0d want %0d", err_cnt, m_cnt); end
        // randomized arbitration-phase bits
        for (int i = 0; i < 60; i++) begin
            can_bus_out = 1'($urandom); sampled_bit = 1'($urandom); rx_mask = 1'($urandom);
            smp_tick = ($urandom_range(0, 2) != 0); bit_tick = 1'($urandom); ssp_tick = 1'($urandom);
            step();
            checks++; if (bt_err !== m_bt || bt_err_dom !== m_dom || arb_lost !== m_arb)
                begin errors++; $display("FAIL arb_rand[%0d] got bt=%b dom=%b arb=%b want %b %b %b", i, bt_err, bt_err_dom, arb_lost, m_bt, m_dom, m_arb); end
            checks++; if (err_cnt !== CW'(m_cnt) || fifo_lvl !== 4'(mq.size()))
                begin errors++; $display("FAIL arb_rand_cnt[%0d] got cnt=%0d lvl=%0d want %0d %0d", i, err_cnt, fifo_lvl, m_cnt, mq.size()); end
        end
    endtask

    task automatic test_data_phase();
        logic [2:0] pat;
        pat = 3'b101;
        rx_mask = 1'b0; xl_data_ph = 1'b1;
        step();
        for (int i = 2; i >= 0; i--) begin
            can_bus_out = pat[i]; bit_tick = 1'b1;
            step();
        end
        checks++; if (fifo_lvl !== 4'd3) begin errors++; $display("FAIL data_lvl3 got %0d want 3", fifo_lvl); end
        sampled_bit = 1'b1; ssp_tick = 1'b1;
        step();
        checks++; if (bt_err !== 1'b0) begin errors++; $display("FAIL data_ssp1_no_err got %b want 0", bt_err); end
        sampled_bit = 1'b1; ssp_tick = 1'b1;
        step();
        checks++; if (bt_err !== 1'b1 || bt_err_dom !== 1'b0)
            begin errors++; $display("FAIL data_ssp2_bit0 got bt=%b dom=%b want 1 0", bt_err, bt_err_dom); end
        checks++; if (fifo_lvl !== 4'd1) begin errors++; $display("FAIL data_lvl1 got %0d want 1", fifo_lvl); end
        sampled_bit = 1'b1; ssp_tick = 1'b1;
        step();
        checks++; if (bt_err !== 1'b0 || arb_lost !== 1'b0 || fifo_lvl !== 4'd0)
            begin errors++; $display("FAIL data_ssp3 got bt=%b arb=%b lvl=%0d want 0 0 0", bt_err, arb_lost, fifo_lvl); end
    endtask

    task automatic test_back_to_back();
        // oldest entry dominant; push a recessive bit while popping
        can_bus_out = 1'b0; rx_mask = 1'b0; bit_tick = 1'b1;
        step();
        can_bus_out = 1'b1; bit_tick = 1'b1; sampled_bit = 1'b1; ssp_tick = 1'b1;
        step();
        checks++; if (bt_err !== 1'b1 || fifo_lvl !== 4'd1)
            begin errors++; $display("FAIL b2b_pop_old got bt=%b lvl=%0d want 1 1", bt_err, fifo_lvl); end
        sampled_bit = 1'b0; ssp_tick = 1'b1;
        step();
        checks++; if (bt_err !== 1'b1 || bt_err_dom !== 1'b1 || fifo_lvl !== 4'd0)
            begin errors++; $display("FAIL b2b_second got bt=%b dom=%b lvl=%0d want 1 1 0", bt_err, bt_err_dom, fifo_lvl); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            can_bus_out = 1'($urandom); rx_mask = 1'($urandom); bit_tick = 1'b1;
            step();
        end
        checks++; if (fifo_lvl !== 4'd8) begin errors++; $display("FAIL ovf_lvl got %0d want 8", fifo_lvl); end
        checks++; if (tdc_err !== 1'b1)  begin errors++; $display("FAIL ovf_tdc_err got %b want 1", tdc_err); end
        xl_data_ph = 1'b0; step();
        xl_data_ph = 1'b1; step();
        checks++; if (fifo_lvl !== 4'd0) begin errors++; $display("FAIL flush_lvl got %0d want 0", fifo_lvl); end
        sampled_bit = 1'b0; ssp_tick = 1'b1;
        step();
        checks++; if (tdc_err !== 1'b1 || bt_err !== 1'b0)
            begin errors++; $display("FAIL udf got tdc=%b bt=%b want 1 0", tdc_err, bt_err); end
        err_clr = 1'b1;
        step();
        checks++; if (tdc_err !== 1'b0) begin errors++; $display("FAIL tdc_clr got %b want 0", tdc_err); end
        // underflow coincident with clear keeps the flag set
        ssp_tick = 1'b1; err_clr = 1'b1;
        step();
        checks++; if (tdc_err !== 1'b1) begin errors++; $display("FAIL tdc_set_over_clr got %b want 1", tdc_err); end
    endtask

    task automatic test_saturation();
        xl_data_ph = 1'b0; rx_mask = 1'b0;
        err_clr = 1'b1; step();
        for (int i = 0; i < 5; i++) begin
            can_bus_out = 1'b0; sampled_bit = 1'b1; smp_tick = 1'b1;
            step();
            checks++; if (err_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, err_cnt, m_cnt); end
        end
`ifdef CANXL_BM_ERR_CNT_EN
        checks++; if (err_cnt !== 2'd3) begin errors++; $display("FAIL sat_final got %0d want 3", err_cnt); end
`endif
        can_bus_out = 1'b0; sampled_bit = 1'b1; smp_tick = 1'b1; err_clr = 1'b1;
        step();
        checks++; if (err_cnt !== 2'd0 || bt_err !== 1'b1)
            begin errors++; $display("FAIL clr_priority got cnt=%0d bt=%b want 0 1", err_cnt, bt_err); end
    endtask

    task automatic test_async_reset();
        xl_data_ph = 1'b1; rx_mask = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            can_bus_out = 1'b0; bit_tick = 1'b1;
            step();
        end
        can_bus_out = 1'b0; sampled_bit = 1'b1; ssp_tick = 1'b1;
        step();
        bit_tick = 1'b1; can_bus_out = 1'b1;
        step();
        checks++; if (fifo_lvl !== 4'd4 || bt_err !== 1'b0)
            begin errors++; $display("FAIL pre_rst got lvl=%0d bt=%b want 4 0", fifo_lvl, bt_err); end
        can_bus_out = 1'b0; sampled_bit = 1'b1; ssp_tick = 1'b1;
        #2;
        g_rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if ({bt_err, bt_err_dom, arb_lost, tdc_err} !== 4'b0 || err_cnt !== '0 || fifo_lvl !== 4'd0)
            begin errors++; $display("FAIL async_rst got bt=%b dom=%b arb=%b tdc=%b cnt=%0d lvl=%0d want all 0",
                bt_err, bt_err_dom, arb_lost, tdc_err, err_cnt, fifo_lvl); end
        @(negedge clk);
        g_rst_n = 1'b1;
        ssp_tick = 1'b1; sampled_bit = 1'b1;
        step();
        checks++; if (tdc_err !== 1'b1 || bt_err !== 1'b0)
            begin errors++; $display("FAIL post_rst_udf got tdc=%b bt=%b want 1 0", tdc_err, bt_err); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            mon_en      = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 24) == 0) xl_data_ph = ~xl_data_ph;
            bit_tick    = ($urandom_range(0, 2) == 0);
            ssp_tick    = ($urandom_range(0, 2) == 0);
            smp_tick    = ($urandom_range(0, 2) == 0);
            can_bus_out = 1'($urandom);
            sampled_bit = 1'($urandom);
            rx_mask     = ($urandom_range(0, 3) == 0);
            err_clr     = ($urandom_range(0, 29) == 0);
            step();
            checks++; if (bt_err !== m_bt || bt_err_dom !== m_dom || arb_lost !== m_arb)
                begin errors++; $display("FAIL rand_evt[%0d] got bt=%b dom=%b arb=%b want %b %b %b", i, bt_err, bt_err_dom, arb_lost, m_bt, m_dom, m_arb); end
            checks++; if (tdc_err !== m_tdc || fifo_lvl !== 4'(mq.size()) || err_cnt !== CW'(m_cnt))
                begin errors++; $display("FAIL rand_state[%0d] got tdc=%b lvl=%0d cnt=%0d want %b %0d %0d", i, tdc_err, fifo_lvl, err_cnt, m_tdc, mq.size(), m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_data_phase();
        test_back_to_back();
        test_overflow();
        test_saturation();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
